// File: rtl/mult_wb_queue_pkg.sv
// Shared sizing defaults for the multiplier write-back queue and the
// occupancy-change encoding used by its pointer/count logic.
package mult_wb_queue_pkg;

    localparam int MWB_DEPTH  = 4;
    localparam int MWB_DATA_W = 8;
    localparam int MWB_ADDR_W = 3;
    localparam int MWB_PTR_W  = $clog2(MWB_DEPTH);

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } mwb_op_e;

    function automatic mwb_op_e op_of(input logic push, input logic pop);
        return mwb_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/mult_wb_entry_store.sv
// Entry storage for the write-back queue: data/dest registers, valid bits,
// tail write, head read and a youngest-first destination match.
module mult_wb_entry_store
    import mult_wb_queue_pkg::*;
#(
    parameter int DEPTH  = MWB_DEPTH,
    parameter int DATA_W = MWB_DATA_W,
    parameter int ADDR_W = MWB_ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [$clog2(DEPTH)-1:0]   tail_ptr,
    input  logic [$clog2(DEPTH)-1:0]   head_ptr,
    input  logic [ADDR_W-1:0]          push_dest,
    input  logic [DATA_W-1:0]          push_data,
    input  logic [ADDR_W-1:0]          lookup_addr,
    output logic [ADDR_W-1:0]          head_dest,
    output logic [DATA_W-1:0]          head_data,
    output logic                       lookup_hit,
    output logic [DATA_W-1:0]          lookup_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [ADDR_W-1:0] dest_d [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [PTR_W-1:0]  idx_s;
    logic              match_s;

    // Per-entry next state: a push at the tail wins over a pop at the head.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
            dest_d[i] = dest_q[i];
            if (push && (tail_ptr == PTR_W'(i))) begin
                valid_d[i] = 1'b1;
                data_d[i]  = push_data;
                dest_d[i]  = push_dest;
            end else if (pop && (head_ptr == PTR_W'(i))) begin
                valid_d[i] = 1'b0;
            end else begin
                valid_d[i] = valid_q[i];
            end
        end
    end

    // Entry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= {DATA_W{1'b0}};
                dest_q[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
                dest_q[i] <= dest_d[i];
            end
        end
    end

    assign head_dest = valid_q[head_ptr] ? dest_q[head_ptr] : {ADDR_W{1'b0}};
    assign head_data = valid_q[head_ptr] ? data_q[head_ptr] : {DATA_W{1'b0}};

    // Walk back from the newest entry (tail-1) so the youngest match wins.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = {DATA_W{1'b0}};
        idx_s       = {PTR_W{1'b0}};
        match_s     = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s       = tail_ptr - PTR_W'(k + 1);
            match_s     = valid_q[idx_s] && (dest_q[idx_s] == lookup_addr) && !lookup_hit;
            lookup_data = match_s ? data_q[idx_s] : lookup_data;
            lookup_hit  = lookup_hit | match_s;
        end
    end

endmodule

// File: rtl/mult_wb_queue.sv
// Write-back queue behind the array multiplier: buffers {dest, product} and
// drains one entry per cycle into the register file when its port is free.
module mult_wb_queue
    import mult_wb_queue_pkg::*;
#(
    parameter int DEPTH  = MWB_DEPTH,
    parameter int DATA_W = MWB_DATA_W,
    parameter int ADDR_W = MWB_ADDR_W
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [DATA_W-1:0]            IN_PRODUCT,
    input  logic [ADDR_W-1:0]            IN_DEST,
    input  logic                         PORT_BUSY,
    output logic                         WB_WRITE,
    output logic [ADDR_W-1:0]            WB_ADDRESS,
    output logic [DATA_W-1:0]            WB_DATA,
    input  logic [ADDR_W-1:0]            LOOKUP_ADDR,
    output logic                         LOOKUP_HIT,
    output logic [DATA_W-1:0]            LOOKUP_DATA,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT,
    output logic                         EMPTY
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] head_d;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] tail_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;

    assign empty_s = (count_q == {CNT_W{1'b0}});
    assign full_s  = (count_q == CNT_W'(DEPTH));
    // Full blocks a push even when the head drains on the same edge.
    assign push_s  = IN_VALID && !full_s;
    assign pop_s   = !empty_s && !PORT_BUSY;

    // Pointer and occupancy next state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (op_of(push_s, pop_s))
            OP_PUSH: begin
                tail_d  = tail_q + PTR_W'(1);
                count_d = count_q + CNT_W'(1);
            end
            OP_POP: begin
                head_d  = head_q + PTR_W'(1);
                count_d = count_q - CNT_W'(1);
            end
            OP_BOTH: begin
                head_d = head_q + PTR_W'(1);
                tail_d = tail_q + PTR_W'(1);
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    mult_wb_entry_store #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_store (
        .clk         (CLK),
        .rst         (RESET),
        .push        (push_s),
        .pop         (pop_s),
        .tail_ptr    (tail_q),
        .head_ptr    (head_q),
        .push_dest   (IN_DEST),
        .push_data   (IN_PRODUCT),
        .lookup_addr (LOOKUP_ADDR),
        .head_dest   (WB_ADDRESS),
        .head_data   (WB_DATA),
        .lookup_hit  (LOOKUP_HIT),
        .lookup_data (LOOKUP_DATA)
    );

    assign IN_READY = !full_s;
    assign WB_WRITE = pop_s;
    assign COUNT    = count_q;
    assign EMPTY    = empty_s;

endmodule

// File: tb/tb_mult_wb_queue.sv
// Self-checking bench for mult_wb_queue against a queue-based reference model.
module tb_mult_wb_queue;

    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [7:0] IN_PRODUCT = 8'h00;
    logic [2:0] IN_DEST = 3'd0;
    logic       PORT_BUSY = 1'b0;
    logic       WB_WRITE;
    logic [2:0] WB_ADDRESS;
    logic [7:0] WB_DATA;
    logic [2:0] LOOKUP_ADDR = 3'd0;
    logic       LOOKUP_HIT;
    logic [7:0] LOOKUP_DATA;
    logic [2:0] COUNT;
    logic       EMPTY;

    int errors = 0;
    int checks = 0;

    // Reference model: {dest, product} entries, oldest at index 0.
    logic [10:0] mq[$];
    logic [10:0] wlog[$];

    mult_wb_queue dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_PRODUCT(IN_PRODUCT), .IN_DEST(IN_DEST), .PORT_BUSY(PORT_BUSY),
        .WB_WRITE(WB_WRITE), .WB_ADDRESS(WB_ADDRESS), .WB_DATA(WB_DATA),
        .LOOKUP_ADDR(LOOKUP_ADDR), .LOOKUP_HIT(LOOKUP_HIT), .LOOKUP_DATA(LOOKUP_DATA),
        .COUNT(COUNT), .EMPTY(EMPTY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic exp_write();
        return (mq.size() != 0) && !PORT_BUSY;
    endfunction
    function automatic logic [2:0] exp_addr();
        return (mq.size() != 0) ? mq[0][10:8] : 3'd0;
    endfunction
    function automatic logic [7:0] exp_data();
        return (mq.size() != 0) ? mq[0][7:0] : 8'h00;
    endfunction
    function automatic logic exp_hit(input logic [2:0] a);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i][10:8] == a) return 1'b1;
        return 1'b0;
    endfunction
    function automatic logic [7:0] exp_ldata(input logic [2:0] a);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i][10:8] == a) return mq[i][7:0];
        return 8'h00;
    endfunction

    // Advance one clock edge, updating the model from the pre-edge inputs.
    task automatic tick();
        bit do_pop;
        bit do_push;
        logic [10:0] e;
        do_pop  = (mq.size() != 0) && !PORT_BUSY && !RESET;
        do_push = IN_VALID && (mq.size() < DEPTH) && !RESET;
        e = {IN_DEST, IN_PRODUCT};
        @(posedge CLK);
        if (RESET) begin
            mq.delete();
        end else begin
            if (do_pop) begin
                wlog.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (do_push) mq.push_back(e);
        end
        #1;
    endtask

    task automatic push(input logic [2:0] d, input logic [7:0] p);
        IN_VALID = 1'b1; IN_DEST = d; IN_PRODUCT = p;
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        IN_VALID = 1'b0;
        PORT_BUSY = 1'b0;
        for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) tick();
        #1;
        checks++;
        if (EMPTY !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", EMPTY); end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        #1;
        checks++;
        if (COUNT !== 3'd0 || EMPTY !== 1'b1 || IN_READY !== 1'b1 || WB_WRITE !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: count=%0d empty=%b ready=%b wr=%b want 0 1 1 0", COUNT, EMPTY, IN_READY, WB_WRITE);
        end
        tick(); tick();
        RESET = 1'b0;
        #1;
        checks++;
        if (COUNT !== 3'd0 || EMPTY !== 1'b1 || IN_READY !== 1'b1 || WB_WRITE !== 1'b0 || WB_DATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle: count=%0d empty=%b ready=%b wr=%b data=%h", COUNT, EMPTY, IN_READY, WB_WRITE, WB_DATA);
        end
        for (int a = 0; a < 8; a++) begin
            LOOKUP_ADDR = 3'(a);
            #1;
            checks++;
            if (LOOKUP_HIT !== 1'b0 || LOOKUP_DATA !== 8'h00) begin
                errors++;
                $display("FAIL reset_lookup a=%0d: hit=%b data=%h want 0 00", a, LOOKUP_HIT, LOOKUP_DATA);
            end
        end
    endtask

    task automatic test_single();
        PORT_BUSY = 1'b0;
        push(3'd3, 8'hB5);
        #1;
        checks++;
        if (WB_WRITE !== 1'b1 || WB_ADDRESS !== 3'd3 || WB_DATA !== 8'hB5) begin
            errors++;
            $display("FAIL single_wb: wr=%b addr=%0d data=%h want 1 3 b5", WB_WRITE, WB_ADDRESS, WB_DATA);
        end
        tick();
        checks++;
        if (EMPTY !== 1'b1 || WB_WRITE !== 1'b0) begin
            errors++;
            $display("FAIL single_empty: empty=%b wr=%b want 1 0", EMPTY, WB_WRITE);
        end
    endtask

    task automatic test_fill();
        PORT_BUSY = 1'b1;
        for (int i = 1; i <= 4; i++) push(3'(i), 8'(i));
        IN_VALID = 1'b1; IN_DEST = 3'd5; IN_PRODUCT = 8'h05;
        #1;
        checks++;
        if (IN_READY !== 1'b0 || COUNT !== 3'd4) begin
            errors++;
            $display("FAIL fill_full: ready=%b count=%0d want 0 4", IN_READY, COUNT);
        end
        tick();
        IN_VALID = 1'b0;
        PORT_BUSY = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if (WB_WRITE !== 1'b1 || WB_ADDRESS !== 3'(i) || WB_DATA !== 8'(i)) begin
                errors++;
                $display("FAIL fill_drain%0d: wr=%b addr=%0d data=%h want 1 %0d %h", i, WB_WRITE, WB_ADDRESS, WB_DATA, i, 8'(i));
            end
            tick();
        end
        checks++;
        if (EMPTY !== 1'b1) begin errors++; $display("FAIL fill_no_fifth: empty=%b want 1", EMPTY); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] sent[$];
        PORT_BUSY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sent.push_back({3'($urandom), 8'($urandom)});
            push(sent[i][10:8], sent[i][7:0]);
        end
        PORT_BUSY = 1'b0;
        wlog.delete();
        for (int i = 0; i < 5; i++) begin
            sent.push_back({3'($urandom), 8'($urandom)});
            IN_VALID = 1'b1; IN_DEST = sent[$][10:8]; IN_PRODUCT = sent[$][7:0];
            #1;
            checks++;
            if (COUNT !== 3'd2 || WB_WRITE !== 1'b1 || WB_DATA !== sent[i][7:0] || WB_ADDRESS !== sent[i][10:8]) begin
                errors++;
                $display("FAIL b2b_%0d: count=%0d wr=%b addr=%0d data=%h want 2 1 %0d %h", i, COUNT, WB_WRITE, WB_ADDRESS, WB_DATA, sent[i][10:8], sent[i][7:0]);
            end
            tick();
        end
        IN_VALID = 1'b0;
        drain();
        checks++;
        if (wlog.size() != sent.size() || wlog != sent) begin
            errors++;
            $display("FAIL b2b_order: wrote %0d entries want %0d in order", wlog.size(), sent.size());
        end
    endtask

    task automatic test_forward();
        PORT_BUSY = 1'b1;
        push(3'd5, 8'h10);
        push(3'd5, 8'h20);
        LOOKUP_ADDR = 3'd5;
        #1;
        checks++;
        if (LOOKUP_HIT !== 1'b1 || LOOKUP_DATA !== 8'h20) begin
            errors++;
            $display("FAIL fwd_young: hit=%b data=%h want 1 20", LOOKUP_HIT, LOOKUP_DATA);
        end
        LOOKUP_ADDR = 3'd6;
        #1;
        checks++;
        if (LOOKUP_HIT !== 1'b0 || LOOKUP_DATA !== 8'h00) begin
            errors++;
            $display("FAIL fwd_miss: hit=%b data=%h want 0 00", LOOKUP_HIT, LOOKUP_DATA);
        end
        LOOKUP_ADDR = 3'd5;
        PORT_BUSY = 1'b0;
        #1;
        checks++;
        if (LOOKUP_HIT !== 1'b1 || WB_WRITE !== 1'b1) begin
            errors++;
            $display("FAIL fwd_popping_head: hit=%b wr=%b want 1 1", LOOKUP_HIT, WB_WRITE);
        end
        tick();
        #1;
        checks++;
        if (LOOKUP_HIT !== 1'b1 || LOOKUP_DATA !== 8'h20) begin
            errors++;
            $display("FAIL fwd_after_pop: hit=%b data=%h want 1 20", LOOKUP_HIT, LOOKUP_DATA);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        PORT_BUSY = 1'b1;
        for (int i = 0; i < 3; i++) push(3'(i + 1), 8'($urandom));
        PORT_BUSY = 1'b0;
        #1;
        checks++;
        if (WB_WRITE !== 1'b1 || COUNT !== 3'd3) begin
            errors++;
            $display("FAIL rstmid_pre: wr=%b count=%0d want 1 3", WB_WRITE, COUNT);
        end
        #1 RESET = 1'b1;
        #1;
        mq.delete();
        checks++;
        if (WB_WRITE !== 1'b0 || COUNT !== 3'd0 || EMPTY !== 1'b1 || WB_DATA !== 8'h00 || IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async: wr=%b count=%0d empty=%b data=%h ready=%b", WB_WRITE, COUNT, EMPTY, WB_DATA, IN_READY);
        end
        @(negedge CLK);
        RESET = 1'b0;
        tick();
        checks++;
        if (WB_WRITE !== 1'b0 || EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_stale: wr=%b empty=%b want 0 1", WB_WRITE, EMPTY);
        end
        for (int i = 0; i < 10; i++) begin
            IN_VALID = 1'b1; IN_DEST = 3'($urandom); IN_PRODUCT = 8'($urandom);
            PORT_BUSY = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (WB_WRITE !== exp_write() || WB_DATA !== exp_data() || WB_ADDRESS !== exp_addr() || COUNT !== 3'(mq.size())) begin
                errors++;
                $display("FAIL rstmid_wrap%0d: wr=%b addr=%0d data=%h count=%0d want %b %0d %h %0d", i, WB_WRITE, WB_ADDRESS, WB_DATA, COUNT, exp_write(), exp_addr(), exp_data(), mq.size());
            end
            tick();
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            IN_VALID = 1'($urandom_range(0, 2) != 0);
            PORT_BUSY = 1'($urandom_range(0, 2) == 0);
            LOOKUP_ADDR = 3'($urandom);
            if (IN_VALID) begin
                IN_DEST = 3'($urandom_range(0, 3));
                IN_PRODUCT = 8'($urandom);
            end else begin
                IN_DEST = 3'bxxx;
                IN_PRODUCT = 8'hxx;
            end
            #1;
            checks++;
            if (WB_WRITE !== exp_write() || WB_ADDRESS !== exp_addr() || WB_DATA !== exp_data() ||
                COUNT !== 3'(mq.size()) || EMPTY !== (mq.size() == 0) || IN_READY !== (mq.size() != DEPTH) ||
                LOOKUP_HIT !== exp_hit(LOOKUP_ADDR) || LOOKUP_DATA !== exp_ldata(LOOKUP_ADDR)) begin
                errors++;
                $display("FAIL random%0d: wr=%b addr=%0d data=%h cnt=%0d rdy=%b hit=%b ld=%h want %b %0d %h %0d %b %b %h",
                         i, WB_WRITE, WB_ADDRESS, WB_DATA, COUNT, IN_READY, LOOKUP_HIT, LOOKUP_DATA,
                         exp_write(), exp_addr(), exp_data(), mq.size(), (mq.size() != DEPTH),
                         exp_hit(LOOKUP_ADDR), exp_ldata(LOOKUP_ADDR));
            end
            tick();
        end
        IN_DEST = 3'd0;
        IN_PRODUCT = 8'h00;
        drain();
    endtask

    initial begin
        @(posedge CLK);
        #1;
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_forward();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
